oufbuf_ctrl: RTL and testbench
==============================

# oufbuf_ctrl

Frame sequencer for the RGB565 output frame buffer dual-port SRAM (480×272, 17-bit address, 1-cycle registered read). It accepts the CNN output pixel stream and writes one full frame into the SRAM through its write port. It then streams the frame out through the read port to the display/readout side under valid/ready backpressure. It owns the write address, the read address and the single-buffer frame handshake; the SRAM itself is instantiated alongside it.

## Interface
- P_WIDTH, 480, pixels per line
- P_HEIGHT, 272, lines per frame; P_DEPTH = P_WIDTH*P_HEIGHT (130560)
- P_AW, 17, SRAM address width; must satisfy P_DEPTH ≤ 2^P_AW
- P_DW, 16, pixel width (RGB565)

Ports (name, direction, width, meaning):
- iClk  in  1  single clock, rising edge
- iRsn  in  1  reset; **asynchronous, active-low**
- iPixVld  in  1  input pixel valid
- iPixSof  in  1  input pixel is first of frame
- iPixData  in  P_DW  input pixel
- oPixRdy  out  1  controller accepts pixel
- oWrEn  out  1  SRAM write enable
- oWrAddr  out  P_AW  SRAM write address
- oWrData  out  P_DW  SRAM write data
- oRdAddr  out  P_AW  SRAM read address
- iRdData  in  P_DW  SRAM registered read data
- oFrmRdy  out  1  complete frame stored, readout not yet started
- iRdStart  in  1  request readout (single-cycle pulse)
- oOutVld  out  1  output pixel valid
- oOutData  out  P_DW  output pixel
- oOutLast  out  1  output pixel is index P_DEPTH-1
- iOutRdy  in  1  downstream ready
- oBusy  out  1  state ≠ IDLE
- oFrmCnt  out  16  completed readouts (OUFBUF_CTRL_STAT_EN)
- oSofErr  out  1  sticky SOF error (OUFBUF_CTRL_STAT_EN)

## Operation
- FSM states: IDLE, WRITE, READY, READ.
- Input acceptance: a pixel is accepted when iPixVld & oPixRdy. oPixRdy = 1 in IDLE and WRITE, 0 in READY and READ.
- IDLE: an accepted pixel without iPixSof is discarded. An accepted pixel with iPixSof is written to address 0; state → WRITE, write counter = 1.
- WRITE: each accepted pixel is written at the write counter, which then increments.
  - Accepted iPixSof mid-frame: write at 0, counter = 1 (resync), set oSofErr.
  - Write at P_DEPTH-1: state → READY, counter cleared.
- Write outputs: oWrEn = accepted & not discarded. oWrAddr and oWrData are combinational from the counter and iPixData.
- READY: oFrmRdy = 1. iRdStart → READ, read counter = 0. iRdStart in any other state is ignored.
- READ: a 2-entry output FIFO buffers iRdData.
  - Issue read (present the counter on oRdAddr and increment) when the counter < P_DEPTH and (entries + in-flight) < 2. At most one read is in flight.
  - The in-flight word is pushed into the FIFO the cycle after issue.
  - oOutVld = FIFO non-empty. Pop on oOutVld & iOutRdy.
  - oOutLast is tagged on the word read from P_DEPTH-1.
  - Pop of the last word: state → IDLE, oFrmCnt increments (wraps at 2^16).
- oRdAddr holds its last value when no read is issued.
- Reset (any time): state IDLE, counters 0, FIFO empty, in-flight cleared. SRAM contents are not cleared.

## Timing
- Reset values: oPixRdy 1, oWrEn 0, oWrAddr 0, oWrData = iPixData (combinational), oRdAddr 0, oFrmRdy 0, oOutVld 0, oOutData 0, oOutLast 0, oBusy 0, oFrmCnt 0, oSofErr 0.
- Write path: zero latency; the accept cycle is the SRAM write cycle.
- Frame ready: oFrmRdy rises the cycle after the edge that writes P_DEPTH-1.
- Read latency: with iRdStart sampled at edge E0, address 0 is presented after E0, the SRAM captures it at E1, and it is pushed at E2. oOutVld is first high after E2, i.e. 2 cycles after the start edge.
- Read throughput: 1 pixel/cycle sustained while iOutRdy = 1.
- Backpressure: with iOutRdy = 0 the FIFO fills to 2 and issue stops. No data is lost, and oOutData/oOutLast are stable while oOutVld & !iOutRdy.

## Configuration
- OUFBUF_CTRL_STAT_EN
  - Defined: oFrmCnt counts completed readouts; oSofErr is sticky, cleared only by reset.
  - Undefined: both ports are present and tied to 0, and the counter logic is removed.

## Structure
- Shared package oufbuf_pkg: state encoding (IDLE/WRITE/READY/READ), and the P_WIDTH/P_HEIGHT/P_DEPTH/P_AW/P_DW defaults shared with the SRAM.
- One natural sub-module: oufbuf_rd_fifo, a 2-entry pixel+last FIFO with push/pop/count.

## Test plan
Benches use P_WIDTH=4, P_HEIGHT=2 (P_DEPTH=8) unless noted.
- Write a full frame: 8 pixels 0x1000..0x1007, SOF on the first. Expect oWrAddr 0..7 with matching data, oFrmRdy=1 the cycle after, and oPixRdy=0.
- Discard in IDLE: 3 pixels without SOF, then a frame. Expect no oWrEn for the 3, then the first write at addr 0.
- Readout with iOutRdy=1: pulse iRdStart. Expect oOutVld 2 cycles later and data 0x1000..0x1007 on consecutive cycles, oOutLast on 0x1007. Then oBusy=0 and oFrmCnt=1.
- Backpressure: toggle iOutRdy randomly during readout. Expect all 8 words in order, stable data when stalled, and no more than 2 buffered.
- SOF mid-frame: SOF at pixel 5. Expect a write at addr 0, oSofErr=1, and READY only after 8 more pixels.
- Reset mid-READ: drop iRsn after 3 pops. Expect every output at its reset value; a new SOF frame then writes from addr 0.

Source files
------------

// File: rtl/oufbuf_pkg.sv
// Shared constants and FSM state encoding for the output frame buffer sequencer.
// The frame geometry defaults match the SRAM instantiated next to oufbuf_ctrl.
package oufbuf_pkg;

  localparam int P_WIDTH  = 480;
  localparam int P_HEIGHT = 272;
  localparam int P_DEPTH  = P_WIDTH * P_HEIGHT;
  localparam int P_AW     = 17;
  localparam int P_DW     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READY = 2'd2,
    ST_READ  = 2'd3
  } state_t;

endpackage

// File: rtl/oufbuf_rd_fifo.sv
// Two-entry pixel+last FIFO that absorbs the SRAM read latency during readout.
// The head entry stays stable while it is not popped.
module oufbuf_rd_fifo #(
  parameter int P_DW = 16
) (
  input  logic            iClk,
  input  logic            iRsn,
  input  logic            iPush,
  input  logic [P_DW-1:0] iPushData,
  input  logic            iPushLast,
  input  logic            iPop,
  output logic            oVld,
  output logic [P_DW-1:0] oData,
  output logic            oLast,
  output logic [1:0]      oCnt
);

  logic [P_DW-1:0] r_data [2];
  logic            r_last [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_cnt;
  logic            w_push;
  logic            w_pop;

  assign w_pop  = iPop & (r_cnt != 2'd0);
  assign w_push = iPush & ((r_cnt != 2'd2) | w_pop);

  // storage, pointers and occupancy
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= {P_DW{1'b0}};
        r_last[i] <= 1'b0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= iPushData;
        r_last[r_wr_ptr] <= iPushLast;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign oVld  = (r_cnt != 2'd0);
  assign oData = r_data[r_rd_ptr];
  assign oLast = r_last[r_rd_ptr] & oVld;
  assign oCnt  = r_cnt;

endmodule

// File: rtl/oufbuf_ctrl.sv
// Single-buffer frame sequencer: writes one CNN output frame into the SRAM, then streams it out.
// Optional statistics (readout counter, sticky SOF error) enabled by OUFBUF_CTRL_STAT_EN.
module oufbuf_ctrl #(
  parameter int P_WIDTH  = oufbuf_pkg::P_WIDTH,
  parameter int P_HEIGHT = oufbuf_pkg::P_HEIGHT,
  parameter int P_AW     = oufbuf_pkg::P_AW,
  parameter int P_DW     = oufbuf_pkg::P_DW
) (
  input  logic            iClk,
  input  logic            iRsn,
  input  logic            iPixVld,
  input  logic            iPixSof,
  input  logic [P_DW-1:0] iPixData,
  output logic            oPixRdy,
  output logic            oWrEn,
  output logic [P_AW-1:0] oWrAddr,
  output logic [P_DW-1:0] oWrData,
  output logic [P_AW-1:0] oRdAddr,
  input  logic [P_DW-1:0] iRdData,
  output logic            oFrmRdy,
  input  logic            iRdStart,
  output logic            oOutVld,
  output logic [P_DW-1:0] oOutData,
  output logic            oOutLast,
  input  logic            iOutRdy,
  output logic            oBusy,
  output logic [15:0]     oFrmCnt,
  output logic            oSofErr
);

  import oufbuf_pkg::*;

  localparam int              LP_DEPTH     = P_WIDTH * P_HEIGHT;
  localparam logic [P_AW-1:0] LP_LAST_ADDR = P_AW'(LP_DEPTH - 1);
  localparam logic [P_AW:0]   LP_DEPTH_CNT = (P_AW + 1)'(LP_DEPTH);

  state_t          r_state;
  state_t          w_next_state;
  logic [P_AW-1:0] r_wr_cnt;
  logic [P_AW:0]   r_rd_cnt;
  logic [P_AW-1:0] r_rd_hold;
  logic            r_inflight;
  logic            r_inflight_last;

  logic            w_pix_rdy;
  logic            w_in_read;
  logic            w_acc;
  logic            w_wr_en;
  logic [P_AW-1:0] w_wr_addr;
  logic            w_wr_last;
  logic            w_fifo_vld;
  logic            w_fifo_last;
  logic [1:0]      w_fifo_cnt;
  logic            w_pop;
  logic            w_last_pop;
  logic            w_issue;
  logic [2:0]      w_occ;

  assign w_acc      = iPixVld & w_pix_rdy;
  assign w_wr_en    = w_acc & (iPixSof | (r_state == ST_WRITE));
  assign w_wr_addr  = iPixSof ? {P_AW{1'b0}} : r_wr_cnt;
  assign w_wr_last  = w_wr_en & (w_wr_addr == LP_LAST_ADDR);
  assign w_pop      = w_fifo_vld & iOutRdy;
  assign w_last_pop = w_pop & w_fifo_last;

  // A pop in the same cycle frees a slot, which keeps readout at one pixel per cycle.
  assign w_occ   = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = w_in_read & (r_rd_cnt < LP_DEPTH_CNT) & (w_occ < 3'd2);

  // state register
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  w_next_state = w_wr_last ? ST_READY : (w_wr_en ? ST_WRITE : ST_IDLE);
      ST_WRITE: w_next_state = w_wr_last ? ST_READY : ST_WRITE;
      ST_READY: w_next_state = iRdStart ? ST_READ : ST_READY;
      ST_READ:  w_next_state = w_last_pop ? ST_IDLE : ST_READ;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    w_pix_rdy = 1'b0;
    oFrmRdy   = 1'b0;
    w_in_read = 1'b0;
    oBusy     = 1'b1;
    case (r_state)
      ST_IDLE:  begin w_pix_rdy = 1'b1; oBusy = 1'b0; end
      ST_WRITE: w_pix_rdy = 1'b1;
      ST_READY: oFrmRdy = 1'b1;
      ST_READ:  w_in_read = 1'b1;
      default:  begin w_pix_rdy = 1'b0; oBusy = 1'b0; end
    endcase
  end

  // write address counter and read issue bookkeeping
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_wr_cnt        <= {P_AW{1'b0}};
      r_rd_cnt        <= {(P_AW + 1){1'b0}};
      r_rd_hold       <= {P_AW{1'b0}};
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      if (w_wr_last) begin
        r_wr_cnt <= {P_AW{1'b0}};
      end else if (w_wr_en) begin
        r_wr_cnt <= w_wr_addr + {{(P_AW - 1){1'b0}}, 1'b1};
      end
      if ((r_state == ST_READY) && iRdStart) begin
        r_rd_cnt <= {(P_AW + 1){1'b0}};
      end else if (w_issue) begin
        r_rd_cnt  <= r_rd_cnt + {{P_AW{1'b0}}, 1'b1};
        r_rd_hold <= r_rd_cnt[P_AW-1:0];
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & (r_rd_cnt == (LP_DEPTH_CNT - {{P_AW{1'b0}}, 1'b1}));
    end
  end

  oufbuf_rd_fifo #(.P_DW(P_DW)) u_rd_fifo (
    .iClk      (iClk),
    .iRsn      (iRsn),
    .iPush     (r_inflight),
    .iPushData (iRdData),
    .iPushLast (r_inflight_last),
    .iPop      (w_pop),
    .oVld      (w_fifo_vld),
    .oData     (oOutData),
    .oLast     (w_fifo_last),
    .oCnt      (w_fifo_cnt)
  );

  assign oPixRdy  = w_pix_rdy;
  assign oWrEn    = w_wr_en;
  assign oWrAddr  = w_wr_addr;
  assign oWrData  = iPixData;
  assign oRdAddr  = w_issue ? r_rd_cnt[P_AW-1:0] : r_rd_hold;
  assign oOutVld  = w_fifo_vld;
  assign oOutLast = w_fifo_last;

`ifdef OUFBUF_CTRL_STAT_EN
  logic [15:0] r_frm_cnt;
  logic        r_sof_err;

  // readout counter and sticky mid-frame SOF flag
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_frm_cnt <= 16'd0;
      r_sof_err <= 1'b0;
    end else begin
      if (w_last_pop) begin
        r_frm_cnt <= r_frm_cnt + 16'd1;
      end
      if (w_acc && iPixSof && (r_state == ST_WRITE)) begin
        r_sof_err <= 1'b1;
      end
    end
  end

  assign oFrmCnt = r_frm_cnt;
  assign oSofErr = r_sof_err;
`else
  assign oFrmCnt = 16'd0;
  assign oSofErr = 1'b0;
`endif

endmodule

// File: tb/tb_oufbuf_ctrl.sv
// Randomized scoreboard bench for oufbuf_ctrl on a 4x2 frame with a behavioural SRAM.
// Expected writes and output pixels come from a frame-level reference model.
module tb_oufbuf_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int D  = W * H;
  localparam int AW = 3;
  localparam int DW = 16;

  logic          iClk = 1'b0;
  logic          iRsn = 1'b0;
  logic          iPixVld = 1'b0;
  logic          iPixSof = 1'b0;
  logic [DW-1:0] iPixData = 16'h0000;
  logic          iRdStart = 1'b0;
  logic          iOutRdy = 1'b1;
  logic [DW-1:0] iRdData;
  logic          oPixRdy, oWrEn, oFrmRdy, oOutVld, oOutLast, oBusy, oSofErr;
  logic [AW-1:0] oWrAddr, oRdAddr;
  logic [DW-1:0] oWrData, oOutData;
  logic [15:0]   oFrmCnt;

  always #5 iClk = ~iClk;

  oufbuf_ctrl #(.P_WIDTH(W), .P_HEIGHT(H), .P_AW(AW), .P_DW(DW)) dut (
    .iClk(iClk), .iRsn(iRsn), .iPixVld(iPixVld), .iPixSof(iPixSof), .iPixData(iPixData),
    .oPixRdy(oPixRdy), .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
    .oRdAddr(oRdAddr), .iRdData(iRdData), .oFrmRdy(oFrmRdy), .iRdStart(iRdStart),
    .oOutVld(oOutVld), .oOutData(oOutData), .oOutLast(oOutLast), .iOutRdy(iOutRdy),
    .oBusy(oBusy), .oFrmCnt(oFrmCnt), .oSofErr(oSofErr)
  );

  // dual-port SRAM with registered read
  logic [DW-1:0] mem [D];
  always @(posedge iClk) begin
    if (oWrEn) mem[oWrAddr] <= oWrData;
    iRdData <= mem[oRdAddr];
  end

  int n_vec = 0;
  int n_err = 0;
  int n_pops = 0;

  logic [31:0] q_wr[$];
  logic [16:0] q_out[$];

  int          m_fill = -1;
  bit          m_full = 1'b0;
  bit          m_reading = 1'b0;
  bit          m_err = 1'b0;
  int          m_frm = 0;
  logic [15:0] m_frame [D];
  logic [15:0] m_stored [D];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_frm_cnt();
`ifdef OUFBUF_CTRL_STAT_EN
    return 16'(m_frm);
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic exp_sof_err();
`ifdef OUFBUF_CTRL_STAT_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  // write monitor
  always @(negedge iClk) begin : wr_mon
    logic [31:0] e;
    if (iRsn && oWrEn) begin
      if (q_wr.size() == 0) check("wr_unexpected", {29'd0, oWrAddr}, 32'hFFFF_FFFF);
      else begin
        e = q_wr.pop_front();
        check("wr_addr", {29'd0, oWrAddr}, {16'd0, e[31:16]});
        check("wr_data", {16'd0, oWrData}, {16'd0, e[15:0]});
      end
    end
  end

  // output monitor: ordering, last tag and stability under stall
  logic        prev_stall = 1'b0;
  logic [16:0] prev_out = 17'd0;
  always @(negedge iClk) begin : out_mon
    logic [16:0] e;
    if (!iRsn) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("stall_vld", {31'd0, oOutVld}, 32'd1);
        check("stall_stable", {15'd0, oOutLast, oOutData}, {15'd0, prev_out});
      end
      if (oOutVld && iOutRdy) begin
        if (q_out.size() == 0) check("out_unexpected", {15'd0, oOutLast, oOutData}, 32'hFFFF_FFFF);
        else begin
          e = q_out.pop_front();
          check("out_data", {16'd0, oOutData}, {16'd0, e[15:0]});
          check("out_last", {31'd0, oOutLast}, {31'd0, e[16]});
        end
        n_pops++;
      end
      prev_stall = oOutVld && !iOutRdy;
      prev_out   = {oOutLast, oOutData};
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic send_pix(bit vld, bit sof, logic [15:0] d);
    iPixVld  = vld;
    iPixSof  = sof;
    iPixData = d;
    if (vld && !m_full && !m_reading) begin
      if (sof) begin
        if (m_fill >= 0) m_err = 1'b1;
        m_fill = 0;
      end
      if (m_fill >= 0) begin
        q_wr.push_back({16'(m_fill), d});
        m_frame[m_fill] = d;
        m_fill++;
        if (m_fill == D) begin
          m_full = 1'b1;
          m_fill = -1;
          m_stored = m_frame;
        end
      end
    end
    tick();
    iPixVld = 1'b0;
    iPixSof = 1'b0;
    check("frm_rdy", {31'd0, oFrmRdy}, {31'd0, m_full});
    check("pix_rdy", {31'd0, oPixRdy}, {31'd0, !(m_full || m_reading)});
  endtask

  task automatic random_frame(bit mid_sof);
    int guard = 0;
    int n = 0;
    send_pix(1'b1, 1'b1, 16'($urandom));
    while (!m_full && guard < 200) begin
      guard++;
      if ($urandom_range(0, 3) == 0) send_pix(1'b0, 1'b0, 16'($urandom));
      else begin
        n++;
        send_pix(1'b1, mid_sof && (n == 3), 16'($urandom));
      end
    end
    check("frame_fill_timeout", {31'd0, m_full}, 32'd1);
  endtask

  task automatic readout(bit bp, bit check_lat, int stop_after);
    int cyc = 0;
    int base;
    bit done = 1'b0;
    iOutRdy = 1'b1;
    iRdStart = 1'b1;
    if (m_full) begin
      for (int i = 0; i < D; i++) q_out.push_back({(i == D - 1), m_stored[i]});
      m_full = 1'b0;
      m_reading = 1'b1;
    end
    tick();
    iRdStart = 1'b0;
    base = n_pops;
    if (check_lat) begin
      check("lat_e0", {31'd0, oOutVld}, 32'd0);
      tick();
      check("lat_e1", {31'd0, oOutVld}, 32'd0);
      tick();
      check("lat_e2", {31'd0, oOutVld}, 32'd1);
    end
    while (cyc < 300) begin
      if (stop_after > 0 && n_pops >= base + stop_after) break;
      if (q_out.size() == 0 && !oBusy) begin
        done = 1'b1;
        break;
      end
      iOutRdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cyc++;
    end
    iOutRdy = 1'b1;
    if (stop_after > 0) check("partial_read_timeout", 32'(n_pops - base), 32'(stop_after));
    else begin
      check("read_done", {31'd0, done}, 32'd1);
      if (check_lat && !bp) check("throughput_cycles", 32'(cyc), 32'(D));
      m_reading = 1'b0;
      m_frm++;
      check("busy_after_read", {31'd0, oBusy}, 32'd0);
      check("frm_cnt", {16'd0, oFrmCnt}, {16'd0, exp_frm_cnt()});
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_pix_rdy", {31'd0, oPixRdy}, 32'd1);
    check("rst_wr_en", {31'd0, oWrEn}, 32'd0);
    check("rst_wr_addr", {29'd0, oWrAddr}, 32'd0);
    check("rst_wr_data", {16'd0, oWrData}, {16'd0, iPixData});
    check("rst_rd_addr", {29'd0, oRdAddr}, 32'd0);
    check("rst_frm_rdy", {31'd0, oFrmRdy}, 32'd0);
    check("rst_out_vld", {31'd0, oOutVld}, 32'd0);
    check("rst_out_data", {16'd0, oOutData}, 32'd0);
    check("rst_out_last", {31'd0, oOutLast}, 32'd0);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    check("rst_frm_cnt", {16'd0, oFrmCnt}, 32'd0);
    check("rst_sof_err", {31'd0, oSofErr}, 32'd0);
  endtask

  task automatic apply_reset();
    iPixVld = 1'b0;
    iPixSof = 1'b0;
    iRdStart = 1'b0;
    iOutRdy = 1'b1;
    iPixData = 16'hA5C3;
    iRsn = 1'b0;
    #1;
    check_reset_outputs();
    q_wr.delete();
    q_out.delete();
    m_fill = -1;
    m_full = 1'b0;
    m_reading = 1'b0;
    m_err = 1'b0;
    m_frm = 0;
    tick();
    iRsn = 1'b1;
    tick();
  endtask

  initial begin
    #2;
    iPixData = 16'h5A5A;
    #1;
    check_reset_outputs();
    tick();
    iRsn = 1'b1;
    tick();

    // readout request while idle is ignored
    iRdStart = 1'b1;
    tick();
    iRdStart = 1'b0;
    tick();
    check("start_in_idle", {31'd0, oBusy}, 32'd0);

    // full frame with known data, then a pixel offered while READY
    for (int i = 0; i < D; i++) send_pix(1'b1, i == 0, 16'h1000 + 16'(i));
    send_pix(1'b1, 1'b0, 16'hDEAD);
    readout(1'b0, 1'b1, 0);

    // pixels without SOF in IDLE are discarded
    for (int i = 0; i < 3; i++) send_pix(1'b1, 1'b0, 16'h2000 + 16'(i));
    for (int i = 0; i < D; i++) send_pix(1'b1, i == 0, 16'h3000 + 16'(i));
    readout(1'b1, 1'b0, 0);

    // SOF at pixel 5 resynchronises the frame
    for (int i = 0; i < 5; i++) send_pix(1'b1, i == 0, 16'h4000 + 16'(i));
    send_pix(1'b1, 1'b1, 16'h4100);
    check("sof_err", {31'd0, oSofErr}, {31'd0, exp_sof_err()});
    for (int i = 1; i < D; i++) send_pix(1'b1, 1'b0, 16'h4100 + 16'(i));
    readout(1'b1, 1'b0, 0);

    // randomized frames and backpressure
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) send_pix(1'b1, 1'b0, 16'($urandom));
      random_frame(($urandom_range(0, 2) == 0));
      readout(1'($urandom_range(0, 1)), 1'b0, 0);
    end

    // reset in the middle of a readout
    random_frame(1'b0);
    readout(1'b1, 1'b0, 3);
    apply_reset();
    for (int i = 0; i < D; i++) send_pix(1'b1, i == 0, 16'h6000 + 16'(i));
    readout(1'b1, 1'b0, 0);

    tick();
    check("wr_queue_drained", 32'(q_wr.size()), 32'd0);
    check("out_queue_drained", 32'(q_out.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
